// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle CPU.
// Steps fetch/decode/execute/memory/write-back over the shared datapath.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;

  assign state = r_state;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next state and per-state datapath controls, all forced low in reset.
  always_comb begin
    w_next      = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        w_next  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default: begin
            w_next     = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // IR is not written here, so opcode is still the decoded one.
        w_next  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        w_next     = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_RWB;
      end
      S_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    if (rst) begin
      {PCWrite, PCWriteCond, IorD, MemRead, MemWrite} = '0;
      {MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst} = '0;
      {PCSource, ALUOp, ALUSrcB, instr_done, illegal_op} = '0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm.
// Each cycle's stimulus and expected state/controls are queued together.
module tb_mc_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state;
  logic instr_done, illegal_op;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic       mr;
    logic [5:0] op;
  } stim_t;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] obs();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
            IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp,
            ALUSrcB, instr_done, illegal_op};
  endfunction

  // Reference control table, straight from the state descriptions.
  function automatic logic [17:0] ref_ctl(input logic [3:0] s,
                                          input logic mr,
                                          input logic [5:0] op);
    logic pcw, pcc, iod, mrd, mwr, m2r, irw, asa, rw, rd, dn, ill;
    logic [1:0] pcs, aop, asb;
    {pcw, pcc, iod, mrd, mwr, m2r, irw, asa, rw, rd, dn, ill} = '0;
    {pcs, aop, asb} = '0;
    case (s)
      4'd0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1: begin
        asb = 2'b11;
        ill = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
      end
      4'd2, 4'd10: begin asa = 1; asb = 2'b10; end
      4'd3: begin mrd = 1; iod = 1; end
      4'd4: begin rw = 1; m2r = 1; dn = 1; end
      4'd5: begin mwr = 1; iod = 1; dn = mr; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rd = 1; dn = 1; end
      4'd8: begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; dn = 1; end
      4'd9: begin pcw = 1; pcs = 2'b10; dn = 1; end
      4'd11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pcw, pcc, iod, mrd, mwr, m2r, irw, asa, rw, rd,
            pcs, aop, asb, dn, ill};
  endfunction

  task automatic push(input logic [3:0] s, input logic mr,
                      input logic [5:0] op);
    stim_t si;
    exp_t  ei;
    si.mr = mr;
    si.op = op;
    ei.st = s;
    ei.ctl = ref_ctl(s, mr, op);
    stim_q.push_back(si);
    exp_q.push_back(ei);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Queue one instruction: fw stalls in FETCH, mw stalls in MEMRD/MEMWR.
  task automatic push_instr(input logic [5:0] op, input int fw,
                            input int mw);
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0, op);
    push(4'd0, 1'b1, op);
    push(4'd1, rnd(), op);
    case (op)
      OP_LW: begin
        push(4'd2, rnd(), op);
        for (int i = 0; i < mw; i++) push(4'd3, 1'b0, op);
        push(4'd3, 1'b1, op);
        push(4'd4, rnd(), op);
      end
      OP_SW: begin
        push(4'd2, rnd(), op);
        for (int i = 0; i < mw; i++) push(4'd5, 1'b0, op);
        push(4'd5, 1'b1, op);
      end
      OP_R:    begin push(4'd6, rnd(), op); push(4'd7, rnd(), op); end
      OP_BEQ:  push(4'd8, rnd(), op);
      OP_J:    push(4'd9, rnd(), op);
      OP_ADDI: begin push(4'd10, rnd(), op); push(4'd11, rnd(), op); end
      default: ;
    endcase
  endtask

  initial begin
    stim_t si;
    exp_t  ei;
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_LW;
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctl", 32'(obs()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("fetch_state", 32'(state), 32'd0);
    check("fetch_ctl", 32'(obs()), 32'(ref_ctl(4'd0, 1'b1, OP_LW)));
    check("fetch_memrd", 32'(MemRead & IRWrite & PCWrite), 32'd1);
    check("fetch_asb", 32'(ALUSrcB), 32'd1);
    // Walk an lw into MEMRD, stall there, then reset mid-access.
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    #1;
    check("memrd_state", 32'(state), 32'd3);
    check("memrd_ctl", 32'(obs()), 32'(ref_ctl(4'd3, 1'b0, OP_LW)));
    #1 rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_ctl", 32'(obs()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    push_instr(OP_LW, 0, 0);
    push_instr(OP_SW, 0, 3);
    push_instr(OP_R, 0, 0);
    push_instr(OP_BEQ, 0, 0);
    push_instr(OP_J, 0, 0);
    push_instr(OP_ADDI, 0, 0);
    push_instr(6'b111111, 0, 0);
    push_instr(OP_LW, 2, 1);
    push_instr(OP_ADDI, 1, 0);
    push_instr(OP_SW, 1, 0);
    push_instr(6'b010101, 0, 0);
    push_instr(OP_R, 0, 0);

    while (stim_q.size() > 0) begin
      si = stim_q.pop_front();
      mem_ready = si.mr;
      opcode = si.op;
      #1;
      ei = exp_q.pop_front();
      check("state", 32'(state), 32'(ei.st));
      check("ctl", 32'(obs()), 32'(ei.ctl));
      check("rw_mw_excl", 32'(RegWrite & MemWrite), 32'd0);
      check("irw_fetch", 32'(IRWrite && state != 4'd0), 32'd0);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    #1;
    check("end_fetch", 32'(state), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
